// File: rtl/clk_div_seq_pkg.sv
// Shared types and helpers for the PLL divided-clock and reset-release sequencer.
package clk_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  localparam int LOSS_W = 8;

  // Bits needed to index n items; never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel with a half-period update deferred to the next rising toggle.
module clk_div_ch #(
  parameter int DW       = 8,
  parameter int DEF_HALF = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [DW-1:0] half_i,
  output logic          pend_o,
  output logic          div_o,
  output logic          rise_o
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] half_q, half_d;
  logic [DW-1:0] pval_q, pval_d;
  logic          pend_q, pend_d;
  logic          div_q, div_d;
  logic          rise_q, rise_d;
  logic          toggle;
  logic          apply;

  always_comb begin
    toggle = (cnt_q == half_q);
    cnt_d  = toggle ? '0 : cnt_q + 1'b1;
    div_d  = toggle ? ~div_q : div_q;
    rise_d = toggle & ~div_q;
    // Swapping the half-period only at a rising edge keeps both phases whole.
    apply  = rise_d & pend_q;
    half_d = apply ? pval_q : half_q;
    pval_d = we_i ? half_i : pval_q;
    pend_d = we_i | (pend_q & ~apply);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      half_q <= DW'(DEF_HALF);
      pval_q <= DW'(DEF_HALF);
      pend_q <= 1'b0;
      div_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      pval_q <= pval_d;
      pend_q <= pend_d;
      div_q  <= div_d;
      rise_q <= rise_d;
    end
  end

  assign pend_o = pend_q;
  assign div_o  = div_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/clk_div_seq.sv
// NCH programmable clock dividers plus lock filtering and staged per-channel reset release.
module clk_div_seq
  import clk_div_seq_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int DW        = 8,
  parameter int DEF_HALF  = 1,
  parameter int LOCK_CYC  = 15,
  parameter int STAGE_GAP = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOCK_IN,
  input  logic              CFG_WE,
  input  logic [2:0]        CFG_CH,
  input  logic [DW-1:0]     CFG_HALF,
  output logic [NCH-1:0]    CFG_PEND,
  output logic [NCH-1:0]    DIV_OUT,
  output logic [NCH-1:0]    DIV_RISE,
  output logic [NCH-1:0]    RSTX_OUT,
  output logic              LOCKED,
  output logic [LOSS_W-1:0] LOSS_CNT
);

  localparam int KW  = clog2(NCH);
  localparam int LCW = clog2(LOCK_CYC + 1);
  localparam int GW  = clog2(STAGE_GAP);

  logic              sync_q, lock_s_q;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  seq_state_e        state_q;
  logic [KW-1:0]     k_q;
  logic [GW-1:0]     gap_q;
  logic [NCH-1:0]    rstx_q;
  logic [LOSS_W-1:0] loss_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .DW       (DW),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk_i  (CLK),
      .rst_i  (RST),
      .we_i   (CFG_WE && (CFG_CH == 3'(i))),
      .half_i (CFG_HALF),
      .pend_o (CFG_PEND[i]),
      .div_o  (DIV_OUT[i]),
      .rise_o (DIV_RISE[i])
    );
  end

  always_comb begin
    if (!lock_s_q)                          lock_cnt_d = '0;
    else if (lock_cnt_q == LCW'(LOCK_CYC))  lock_cnt_d = lock_cnt_q;
    else                                    lock_cnt_d = lock_cnt_q + 1'b1;
    locked_d = (lock_cnt_d == LCW'(LOCK_CYC));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= 1'b0;
      lock_s_q   <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      sync_q     <= LOCK_IN;
      lock_s_q   <= sync_q;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // The sequencer follows the next LOCKED value so resets drop on the same edge LOCKED falls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      gap_q   <= '0;
      rstx_q  <= '0;
      loss_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          rstx_q <= '0;
          if (locked_d) begin
            k_q     <= '0;
            gap_q   <= '0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (!locked_d) begin
            rstx_q  <= '0;
            loss_q  <= (loss_q == '1) ? loss_q : loss_q + 1'b1;
            state_q <= ST_IDLE;
          end else if (state_q == ST_RUN) begin
            rstx_q <= '1;
          end else if (gap_q == '0) begin
            rstx_q <= rstx_q | (NCH'(1) << k_q);
            gap_q  <= GW'(STAGE_GAP - 1);
            if (k_q == KW'(NCH - 1)) state_q <= ST_RUN;
            else                     k_q     <= k_q + 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign RSTX_OUT = rstx_q;
  assign LOCKED   = locked_q;
  assign LOSS_CNT = loss_q;

endmodule

// File: tb/tb_clk_div_seq.sv
// Randomised scoreboard bench: an event-time model predicts every output per cycle.
module tb_clk_div_seq;

  localparam int NCH       = 3;
  localparam int DW        = 8;
  localparam int DEF_HALF  = 1;
  localparam int LOCK_CYC  = 15;
  localparam int STAGE_GAP = 4;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           LOCK_IN = 1'b0;
  logic           CFG_WE = 1'b0;
  logic [2:0]     CFG_CH = '0;
  logic [DW-1:0]  CFG_HALF = '0;
  logic [NCH-1:0] CFG_PEND, DIV_OUT, DIV_RISE, RSTX_OUT;
  logic           LOCKED;
  logic [7:0]     LOSS_CNT;

  int checks = 0;
  int failures = 0;
  int cur_cyc = 0;

  typedef struct {
    int           cyc;
    bit           locked;
    bit [NCH-1:0] rstx;
    int           loss;
    bit [NCH-1:0] pend;
    bit [NCH-1:0] div;
    bit [NCH-1:0] rise;
  } exp_t;

  exp_t sq[$];

  clk_div_seq #(
    .NCH(NCH), .DW(DW), .DEF_HALF(DEF_HALF), .LOCK_CYC(LOCK_CYC), .STAGE_GAP(STAGE_GAP)
  ) dut (
    .CLK(CLK), .RST(RST), .LOCK_IN(LOCK_IN), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_HALF(CFG_HALF), .CFG_PEND(CFG_PEND), .DIV_OUT(DIV_OUT), .DIV_RISE(DIV_RISE),
    .RSTX_OUT(RSTX_OUT), .LOCKED(LOCKED), .LOSS_CNT(LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cur_cyc, act, ex);
    end
  endtask

  // Reference model: lock is accepted when LOCK_IN held LOCK_CYC samples ending two
  // cycles back; channel k releases STAGE_GAP*k cycles after the first released one;
  // each divider is tracked as absolute times of its next rise and next fall.
  int  cyc = 0;
  int  run0, run1, run2;
  bit  m_locked, was_locked;
  int  m_loss, rel_at;
  int  nr[NCH], nf[NCH], mh[NCH], mpv[NCH];
  bit  mp[NCH], lvl[NCH];
  exp_t me;

  initial forever begin
    @(posedge CLK);
    cyc++;
    me.cyc  = cyc;
    me.rise = '0;
    if (RST) begin
      run0 = 0; run1 = 0; run2 = 0;
      m_locked = 0; m_loss = 0; rel_at = 0;
      for (int i = 0; i < NCH; i++) begin
        nr[i] = cyc + DEF_HALF + 1; nf[i] = 0;
        mh[i] = DEF_HALF; mpv[i] = DEF_HALF; mp[i] = 0; lvl[i] = 0;
      end
    end else begin
      run2 = run1;
      run1 = run0;
      run0 = LOCK_IN ? ((run0 < 1000) ? run0 + 1 : run0) : 0;
      was_locked = m_locked;
      m_locked = (run2 >= LOCK_CYC);
      if (m_locked && !was_locked) rel_at = cyc + 1;
      if (!m_locked && was_locked && m_loss < 255) m_loss++;
      for (int i = 0; i < NCH; i++) begin
        if (cyc == nr[i]) begin
          if (mp[i]) begin mh[i] = mpv[i]; mp[i] = 0; end
          lvl[i] = 1;
          me.rise[i] = 1;
          nf[i] = cyc + mh[i] + 1;
          nr[i] = cyc + 2 * (mh[i] + 1);
        end else if (cyc == nf[i]) begin
          lvl[i] = 0;
        end
        if (CFG_WE && CFG_CH == i) begin mpv[i] = CFG_HALF; mp[i] = 1; end
      end
    end
    me.locked = m_locked;
    me.loss   = m_loss;
    for (int i = 0; i < NCH; i++) begin
      me.rstx[i] = m_locked && (cyc >= rel_at + STAGE_GAP * i);
      me.pend[i] = mp[i];
      me.div[i]  = lvl[i];
    end
    sq.push_back(me);
  end

  exp_t ce;
  initial forever begin
    @(negedge CLK);
    if (sq.size() > 0) begin
      ce = sq.pop_front();
      cur_cyc = ce.cyc;
      chk("LOCKED", 32'(LOCKED), 32'(ce.locked));
      chk("RSTX_OUT", 32'(RSTX_OUT), 32'(ce.rstx));
      chk("LOSS_CNT", 32'(LOSS_CNT), ce.loss);
      chk("CFG_PEND", 32'(CFG_PEND), 32'(ce.pend));
      chk("DIV_OUT", 32'(DIV_OUT), 32'(ce.div));
      chk("DIV_RISE", 32'(DIV_RISE), 32'(ce.rise));
    end
  end

  task automatic cfg_write(input int ch, input int h);
    CFG_WE = 1'b1; CFG_CH = 3'(ch); CFG_HALF = DW'(h);
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  int r;
  int n;

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    LOCK_IN = 1'b1;
    repeat (40) @(negedge CLK);

    n = 0;
    while (DIV_OUT[1] !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    chk("ch1 high before write", 32'(DIV_OUT[1]), 1);
    cfg_write(1, 4);
    repeat (40) @(negedge CLK);

    cfg_write(0, 2);
    cfg_write(0, 6);
    cfg_write(3, 9);
    repeat (60) @(negedge CLK);

    LOCK_IN = 1'b0;
    @(negedge CLK);
    LOCK_IN = 1'b1;
    repeat (50) @(negedge CLK);

    LOCK_IN = 1'b0;
    repeat (3) @(negedge CLK);
    LOCK_IN = 1'b1;
    n = 0;
    while (RSTX_OUT !== 3'b001 && n < 100) begin @(negedge CLK); n++; end
    chk("reached channel 1 stage", 32'(RSTX_OUT), 32'b001);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(negedge CLK);

    repeat (260) begin
      LOCK_IN = 1'b0;
      @(negedge CLK);
      LOCK_IN = 1'b1;
      repeat (19) @(negedge CLK);
    end

    repeat (3000) begin
      r = $urandom_range(0, 99);
      CFG_WE   = (r < 15);
      CFG_CH   = 3'($urandom_range(0, 7));
      CFG_HALF = DW'($urandom_range(0, 12));
      if (r == 99)     LOCK_IN = 1'b0;
      else if (r >= 90) LOCK_IN = 1'b1;
      RST = ($urandom_range(0, 599) == 0);
      @(negedge CLK);
    end
    CFG_WE = 1'b0;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    #1;
    chk("scoreboard drained", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
